// File: rtl/seq_decoder2to4.sv
// Buffered, pulse-stretching 2-to-4 decoder: queues {en,idx} entries and replays each as a HOLD-cycle one-hot strobe.
// Optional back-to-back slot replay is enabled by defining SEQ_DECODER_B2B_EN.
module seq_decoder2to4 #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [1:0]                   in_idx_i,
  input  logic                         in_en_i,
  output logic [3:0]                   y_o,
  output logic                         y_valid_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int HCW  = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic [2:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  state_t          state_q, state_d;
  logic [HCW-1:0]  hcnt_q, hcnt_d;
  logic [3:0]      y_q, y_d;
  logic            yv_q, yv_d;
  logic            push, pop, empty;
  logic [2:0]      head;

  function automatic logic [3:0] decode(input logic [2:0] e);
    return e[2] ? (4'b0001 << e[1:0]) : 4'b0000;
  endfunction

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign in_ready_o = (count_q != CNTW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    y_d     = y_q;
    yv_d    = yv_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          y_d     = decode(head);
          yv_d    = 1'b1;
          hcnt_d  = HCW'(HOLD - 1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - 1'b1;
        end else begin
`ifdef SEQ_DECODER_B2B_EN
          if (!empty) begin
            // Reload straight from the FIFO head so slots abut with no dead cycle.
            pop    = 1'b1;
            y_d    = decode(head);
            hcnt_d = HCW'(HOLD - 1);
          end else begin
            y_d     = 4'b0000;
            yv_d    = 1'b0;
            state_d = S_IDLE;
          end
`else
          y_d     = 4'b0000;
          yv_d    = 1'b0;
          state_d = S_GAP;
`endif
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        y_d     = 4'b0000;
        yv_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign count_d = count_q + CNTW'(push) - CNTW'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      y_q      <= 4'b0000;
      yv_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= {in_en_i, in_idx_i};
  end

  assign y_o       = y_q;
  assign y_valid_o = yv_q;
  assign count_o   = count_q;
  assign busy_o    = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_decoder2to4.sv
// Randomized bench for seq_decoder2to4 against a slot-timeline reference model.
module tb_seq_decoder2to4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef SEQ_DECODER_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [1:0]    in_idx_i = 2'd0;
  logic          in_en_i = 1'b0;
  logic [3:0]    y_o;
  logic          y_valid_o;
  logic          busy_o;
  logic [CW-1:0] count_o;

  seq_decoder2to4 #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_idx_i(in_idx_i), .in_en_i(in_en_i), .y_o(y_o), .y_valid_o(y_valid_o),
    .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: FIFO contents plus the edge at which the current slot began.
  logic [2:0] mq[$];
  logic [2:0] pend[$];
  logic [2:0] cur = 3'b000;
  bit  have_slot = 1'b0;
  int  last_pop = 0;
  int  npe = 0;
  bit  known = 1'b0;
  bit  hold_v = 1'b0;
  int  vprob = 100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic cycle(input bit r);
    bit m_ready, fire, drive, nonidle;
    logic [3:0] exp_y;
    rst_i = r;
    in_valid_i = (pend.size() > 0) && (hold_v || ($urandom_range(99) < vprob));
    if (in_valid_i) {in_en_i, in_idx_i} = pend[0];
    else            {in_en_i, in_idx_i} = 3'($urandom);
    m_ready = (mq.size() < DEPTH);
    if (known) chk("in_ready_pre", {31'd0, in_ready_o}, {31'd0, m_ready});
    fire = in_valid_i && m_ready && !r;
    edge_n++;
    if (r) begin
      mq.delete();
      have_slot = 1'b0;
      npe = edge_n + 1;
    end else begin
      if (edge_n >= npe) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          have_slot = 1'b1;
          last_pop = edge_n;
          npe = edge_n + HOLD + (B2B ? 0 : 2);
        end else begin
          npe = edge_n + 1;
        end
      end
      if (fire) mq.push_back(pend[0]);
    end
    hold_v = in_valid_i && !fire;
    if (fire) void'(pend.pop_front());
    @(posedge clk_i);
    #1;
    if (r) known = 1'b1;
    if (!known) return;
    drive   = have_slot && (edge_n < last_pop + HOLD);
    nonidle = have_slot && (edge_n < last_pop + HOLD + (B2B ? 0 : 1));
    exp_y   = (drive && cur[2]) ? (4'b0001 << cur[1:0]) : 4'b0000;
    chk("y",        {28'd0, y_o}, {28'd0, exp_y});
    chk("y_valid",  {31'd0, y_valid_o}, {31'd0, drive});
    chk("count",    {{(32-CW){1'b0}}, count_o}, mq.size());
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, (mq.size() < DEPTH)});
    chk("busy",     {31'd0, busy_o}, {31'd0, ((mq.size() > 0) || nonidle)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    cycle(1'b1);
    cycle(1'b1);
    chk("rst_count", {{(32-CW){1'b0}}, count_o}, 0);
    chk("rst_y", {28'd0, y_o}, 0);

    // single strobe idx=2
    vprob = 100;
    pend.push_back(3'b110);
    idle(10);

    // four indices back to back
    for (int i = 0; i < 4; i++) pend.push_back({1'b1, 2'(i)});
    idle(30);

    // five pushes into a slow drain: full stall then late acceptance
    for (int i = 0; i < 5; i++) pend.push_back({1'b1, 2'(3 - (i % 4))});
    idle(40);

    // null slot
    pend.push_back(3'b011);
    idle(8);

    // reset during the second cycle of a 1000 pulse with two queued entries
    pend.push_back(3'b111);
    pend.push_back(3'b101);
    pend.push_back(3'b110);
    idle(3);
    chk("mid_pulse_y", {28'd0, y_o}, 32'h8);
    cycle(1'b1);
    chk("mid_rst_count", {{(32-CW){1'b0}}, count_o}, 0);
    chk("mid_rst_y", {28'd0, y_o}, 0);
    pend.delete();
    hold_v = 1'b0;
    idle(10);

    // randomized traffic with occasional resets
    for (int blk = 0; blk < 15; blk++) begin
      vprob = $urandom_range(100, 10);
      for (int i = 0; i < 200; i++) begin
        while (pend.size() < 3) pend.push_back(3'($urandom));
        cycle($urandom_range(199) == 0);
      end
    end
    pend.delete();
    hold_v = 1'b0;
    idle(30);
    chk("drain_busy", {31'd0, busy_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
